// File: rtl/ring_router_gateway_mux.sv
// Output-side merge of a gateway ring router: worm-locked arbitration of ring/local/ext onto out_ring.
// Optional macro RING_ROUTER_GATEWAY_MUX_OUTREG_EN drives out_ring from a 2-entry skid buffer.
package ring_router_gateway_mux_pkg;
  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic              valid;
    logic              last;
    logic [DATA_W-1:0] data;
  } dii_flit_t;

  typedef enum logic [1:0] {
    PORT_RING  = 2'd0,
    PORT_LOCAL = 2'd1,
    PORT_EXT   = 2'd2
  } port_e;
endpackage

module ring_router_gateway_mux
  import ring_router_gateway_mux_pkg::*;
#(
  parameter int unsigned RING_PRIO = 0
) (
  input  logic      clk,
  input  logic      rst_n,
  input  dii_flit_t in_ring,
  output logic      in_ring_ready,
  input  dii_flit_t in_local,
  output logic      in_local_ready,
  input  dii_flit_t in_ext,
  output logic      in_ext_ready,
  output dii_flit_t out_ring,
  input  logic      out_ring_ready
);

  logic      r_locked;
  port_e     r_owner;
  port_e     r_rr_ptr;

  logic [3:0] w_cand;
  logic      w_pick_vld;
  port_e     w_pick;
  port_e     w_scan;
  port_e     w_sel;
  logic      w_sel_act;
  dii_flit_t w_flit;
  logic      w_in_valid;
  logic      w_accept;
  logic      w_grant;
  logic      w_in_xfer;

  function automatic port_e port_inc(input port_e p);
    case (p)
      PORT_RING:  return PORT_LOCAL;
      PORT_LOCAL: return PORT_EXT;
      default:    return PORT_RING;
    endcase
  endfunction

  assign w_cand = {1'b0, in_ext.valid, in_local.valid, in_ring.valid};

  // Unlocked pick: ring first under RING_PRIO, otherwise cyclic scan from rr_ptr.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = PORT_RING;
    w_scan     = r_rr_ptr;
    if ((RING_PRIO != 0) && in_ring.valid) begin
      w_pick_vld = 1'b1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!w_pick_vld && w_cand[w_scan]) begin
          w_pick_vld = 1'b1;
          w_pick     = w_scan;
        end
        w_scan = port_inc(w_scan);
      end
    end
  end

  assign w_sel     = r_locked ? r_owner : w_pick;
  assign w_sel_act = r_locked | w_pick_vld;

  always_comb begin
    w_flit = '0;
    case (w_sel)
      PORT_RING:  w_flit = in_ring;
      PORT_LOCAL: w_flit = in_local;
      PORT_EXT:   w_flit = in_ext;
      default:    w_flit = '0;
    endcase
  end

  assign w_in_valid = rst_n & w_sel_act & w_flit.valid;
  assign w_grant    = rst_n & w_sel_act & w_accept;
  assign w_in_xfer  = w_in_valid & w_accept;

  assign in_ring_ready  = w_grant & (w_sel == PORT_RING);
  assign in_local_ready = w_grant & (w_sel == PORT_LOCAL);
  assign in_ext_ready   = w_grant & (w_sel == PORT_EXT);

  // Worm lock and round-robin pointer advance on input-side transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_locked <= 1'b0;
      r_owner  <= PORT_RING;
      r_rr_ptr <= PORT_RING;
    end else if (w_in_xfer) begin
      if (w_flit.last) begin
        r_locked <= 1'b0;
        r_rr_ptr <= port_inc(w_sel);
      end else if (!r_locked) begin
        r_locked <= 1'b1;
        r_owner  <= w_sel;
      end
    end
  end

`ifdef RING_ROUTER_GATEWAY_MUX_OUTREG_EN
  logic [1:0] r_cnt;
  dii_flit_t  r_q0;
  dii_flit_t  r_q1;
  logic       w_pop;

  assign w_accept = (r_cnt != 2'd2);
  assign w_pop    = (r_cnt != 2'd0) & out_ring_ready;

  // Two-entry skid buffer; r_q0 is the head presented on out_ring.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 2'd0;
      r_q0  <= '0;
      r_q1  <= '0;
    end else begin
      case ({w_in_xfer, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_q0 <= w_flit;
          else               r_q1 <= w_flit;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_q0  <= r_q1;
          r_cnt <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_q0 <= w_flit;
          end else begin
            r_q0 <= r_q1;
            r_q1 <= w_flit;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_ring = (r_cnt != 2'd0) ? r_q0 : '0;
`else
  assign w_accept = out_ring_ready;
  assign out_ring = w_in_valid ? w_flit : '0;
`endif

endmodule

// File: tb/tb_ring_router_gateway_mux.sv
// Directed bench for ring_router_gateway_mux (both RING_PRIO settings, optional OUTREG build).
module tb_ring_router_gateway_mux;
  import ring_router_gateway_mux_pkg::*;

`ifdef RING_ROUTER_GATEWAY_MUX_OUTREG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic      clk = 1'b0;
  logic      rst_n;
  dii_flit_t ring, loc, ext, out;
  logic      oready, ring_rdy, loc_rdy, ext_rdy;
  dii_flit_t p_ring, p_loc, p_ext, p_out;
  logic      p_oready, p_ring_rdy, p_loc_rdy, p_ext_rdy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] s1_d  [3];
  logic [15:0] src_d [3][2];
  logic [15:0] exp_d [6];
  logic [15:0] got_d [8];
  int          got_c [8];
  int          src_idx [3];
  int          n_out;
  logic [2:0]  rdy;

  always #5 clk = ~clk;

  ring_router_gateway_mux #(.RING_PRIO(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_ring(ring), .in_ring_ready(ring_rdy),
    .in_local(loc), .in_local_ready(loc_rdy),
    .in_ext(ext), .in_ext_ready(ext_rdy),
    .out_ring(out), .out_ring_ready(oready)
  );

  ring_router_gateway_mux #(.RING_PRIO(1)) u_prio (
    .clk(clk), .rst_n(rst_n),
    .in_ring(p_ring), .in_ring_ready(p_ring_rdy),
    .in_local(p_loc), .in_local_ready(p_loc_rdy),
    .in_ext(p_ext), .in_ext_ready(p_ext_rdy),
    .out_ring(p_out), .out_ring_ready(p_oready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic dii_flit_t fl(input logic v, input logic l, input logic [15:0] d);
    dii_flit_t f;
    f.valid = v;
    f.last  = l;
    f.data  = d;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Three 2-flit worms offered together; outputs collected with their cycle index.
  task automatic run_contention();
    for (int s = 0; s < 3; s++) src_idx[s] = 0;
    for (int i = 0; i < 8; i++) begin
      got_d[i] = '0;
      got_c[i] = -1;
    end
    n_out  = 0;
    oready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      ring = (src_idx[0] < 2) ? fl(1'b1, src_idx[0] == 1, src_d[0][src_idx[0] % 2]) : '0;
      loc  = (src_idx[1] < 2) ? fl(1'b1, src_idx[1] == 1, src_d[1][src_idx[1] % 2]) : '0;
      ext  = (src_idx[2] < 2) ? fl(1'b1, src_idx[2] == 1, src_d[2][src_idx[2] % 2]) : '0;
      #2;
      if (out.valid && oready && n_out < 8) begin
        got_d[n_out] = out.data;
        got_c[n_out] = c;
        n_out++;
      end
      rdy = {ext_rdy & ext.valid, loc_rdy & loc.valid, ring_rdy & ring.valid};
      tick();
      for (int s = 0; s < 3; s++) if (rdy[s]) src_idx[s]++;
    end
    ring = '0;
    loc  = '0;
    ext  = '0;
    check("s2_flit_count", 32'(n_out), 32'd6);
    check("s2_in_consumed", 32'(src_idx[0] + src_idx[1] + src_idx[2]), 32'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("s2_order%0d", i), 32'(got_d[i]), 32'(exp_d[i]));
      check($sformatf("s2_cycle%0d", i), 32'(got_c[i]), 32'(i + LAT));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s1_d  = '{16'h0005, 16'h1234, 16'hABCD};
    src_d = '{'{16'hA000, 16'hA001}, '{16'hB000, 16'hB001}, '{16'hC000, 16'hC001}};
    exp_d = '{16'hA000, 16'hA001, 16'hB000, 16'hB001, 16'hC000, 16'hC001};
    rst_n = 1'b0;
    ring = '0; ext = '0; loc = fl(1'b1, 1'b0, 16'h0005); oready = 1'b1;
    p_ring = '0; p_loc = '0; p_ext = '0; p_oready = 1'b1;
    #3;
    check("rst_out_valid", 32'(out.valid), 32'd0);
    check("rst_readies", 32'({ring_rdy, loc_rdy, ext_rdy}), 32'd0);
    check("rst_prio_out_valid", 32'(p_out.valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    loc = '0;
    tick();

`ifdef RING_ROUTER_GATEWAY_MUX_OUTREG_EN
    run_contention();
    ring = fl(1'b1, 1'b1, 16'h9999);
    #2;
    tick();
    ring = '0;
    #1;
    check("s7_buf_valid", 32'(out.valid), 32'd1);
    check("s7_buf_data", 32'(out.data), 32'h9999);
    rst_n = 1'b0;
    #1;
    check("s7_rst_valid", 32'(out.valid), 32'd0);
    check("s7_rst_ready", 32'(ring_rdy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("s7_empty_after_rst", 32'(out.valid), 32'd0);
`else
    // Single-source 3-flit local worm
    for (int k = 0; k < 3; k++) begin
      loc = fl(1'b1, k == 2, s1_d[k]);
      #2;
      check($sformatf("s1_valid%0d", k), 32'(out.valid), 32'd1);
      check($sformatf("s1_data%0d", k), 32'(out.data), 32'(s1_d[k]));
      check($sformatf("s1_last%0d", k), 32'(out.last), 32'(k == 2));
      check($sformatf("s1_loc_rdy%0d", k), 32'(loc_rdy), 32'd1);
      check($sformatf("s1_others_rdy%0d", k), 32'({ring_rdy, ext_rdy}), 32'd0);
      tick();
    end
    loc = '0;
    ring = fl(1'b1, 1'b1, 16'h0111);
    ext  = fl(1'b1, 1'b1, 16'h0222);
    #2;
    check("s1_rr_ext_rdy", 32'(ext_rdy), 32'd1);
    check("s1_rr_ring_rdy", 32'(ring_rdy), 32'd0);
    check("s1_rr_data", 32'(out.data), 32'h0222);
    tick();
    ring = '0;
    ext  = '0;

    run_contention();

    // Ring priority on the RING_PRIO=1 instance
    p_ring = fl(1'b1, 1'b1, 16'h1111);
    p_ext  = fl(1'b1, 1'b1, 16'h2222);
    for (int k = 0; k < 4; k++) begin
      #2;
      check($sformatf("s3_data%0d", k), 32'(p_out.data), 32'h1111);
      check($sformatf("s3_ring_rdy%0d", k), 32'(p_ring_rdy), 32'd1);
      check($sformatf("s3_ext_rdy%0d", k), 32'(p_ext_rdy), 32'd0);
      tick();
    end
    p_ring = '0;
    #2;
    check("s3_ext_after", 32'(p_out.data), 32'h2222);
    check("s3_ext_rdy_after", 32'(p_ext_rdy), 32'd1);
    tick();
    p_ext = '0;

    // Backpressure mid-worm on a ring worm with local waiting
    loc  = fl(1'b1, 1'b1, 16'h5555);
    ring = fl(1'b1, 1'b0, 16'h4000);
    #2;
    check("s4_f0_data", 32'(out.data), 32'h4000);
    check("s4_f0_rdy", 32'(ring_rdy), 32'd1);
    tick();
    ring = fl(1'b1, 1'b0, 16'h4001);
    oready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #2;
      check($sformatf("s4_hold_valid%0d", k), 32'(out.valid), 32'd1);
      check($sformatf("s4_hold_data%0d", k), 32'(out.data), 32'h4001);
      check($sformatf("s4_hold_rdy%0d", k), 32'({ring_rdy, loc_rdy}), 32'd0);
      tick();
    end
    oready = 1'b1;
    #2;
    check("s4_resume_data", 32'(out.data), 32'h4001);
    check("s4_resume_rdy", 32'({ring_rdy, loc_rdy}), 32'b10);
    tick();
    ring = fl(1'b1, 1'b1, 16'h4002);
    #2;
    check("s4_tail_data", 32'(out.data), 32'h4002);
    check("s4_tail_last", 32'(out.last), 32'd1);
    check("s4_tail_rdy", 32'({ring_rdy, loc_rdy}), 32'b10);
    tick();
    ring = '0;
    #2;
    check("s4_local_after", 32'(out.data), 32'h5555);
    check("s4_local_rdy", 32'(loc_rdy), 32'd1);
    tick();
    loc = '0;

    // Bubble: ext owner drops valid while ring waits
    ring = fl(1'b1, 1'b1, 16'h7777);
    ext  = fl(1'b1, 1'b0, 16'h6000);
    #2;
    check("s5_f0_data", 32'(out.data), 32'h6000);
    check("s5_f0_rdy", 32'({ring_rdy, ext_rdy}), 32'b01);
    tick();
    ext = '0;
    for (int k = 0; k < 2; k++) begin
      #2;
      check($sformatf("s5_bubble_valid%0d", k), 32'(out.valid), 32'd0);
      check($sformatf("s5_bubble_ring_rdy%0d", k), 32'(ring_rdy), 32'd0);
      tick();
    end
    ext = fl(1'b1, 1'b0, 16'h6001);
    #2;
    check("s5_f1_data", 32'(out.data), 32'h6001);
    tick();
    ext = fl(1'b1, 1'b1, 16'h6002);
    #2;
    check("s5_f2_data", 32'(out.data), 32'h6002);
    check("s5_f2_last", 32'(out.last), 32'd1);
    check("s5_f2_rdy", 32'(ext_rdy), 32'd1);
    tick();
    ext = '0;
    #2;
    check("s5_ring_after", 32'(out.data), 32'h7777);
    check("s5_ring_rdy_after", 32'(ring_rdy), 32'd1);
    tick();
    ring = '0;

    // Asynchronous reset mid-worm drops the lock
    loc = fl(1'b1, 1'b0, 16'h8000);
    #2;
    check("s6_f0_rdy", 32'(loc_rdy), 32'd1);
    tick();
    loc = fl(1'b1, 1'b0, 16'h8001);
    #2;
    check("s6_f1_data", 32'(out.data), 32'h8001);
    #2;
    rst_n = 1'b0;
    #1;
    check("s6_rst_valid", 32'(out.valid), 32'd0);
    check("s6_rst_readies", 32'({ring_rdy, loc_rdy, ext_rdy}), 32'd0);
    tick();
    rst_n = 1'b1;
    ring = fl(1'b1, 1'b1, 16'h9999);
    #2;
    check("s6_new_data", 32'(out.data), 32'h9999);
    check("s6_new_rdy", 32'({ring_rdy, loc_rdy}), 32'b10);
    tick();
    ring = '0;
    loc  = '0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ring_router_gateway_mux.md
Name: ring_router_gateway_mux

Overview:
Output-side merge stage of a gateway ring router. It combines three DII flit streams onto the outgoing ring link:
- in_ring: pass-through traffic from the gateway demux out_ring port.
- in_local: local injection.
- in_ext: traffic arriving from the external subnet.

Arbitration is per worm (packet), so flits of different packets never interleave on out_ring.

Parameters:
RING_PRIO, 0, 1 = in_ring wins whenever no worm is locked; 0 = round-robin over ring/local/ext.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_ring  input  dii_flit (18: valid, last, data[15:0])  pass-through ring stream
in_ring_ready  output  1  in_ring accept
in_local  input  dii_flit  local injection stream
in_local_ready  output  1  in_local accept
in_ext  input  dii_flit  external subnet stream
in_ext_ready  output  1  in_ext accept
out_ring  output  dii_flit  merged outgoing ring stream
out_ring_ready  input  1  downstream accept

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n low clears locked=0, owner=RING, rr_ptr=RING (next preferred = RING).
  - While in reset, out_ring.valid=0 and all *_ready=0.
- Transfer: occurs on an input when in_x.valid & in_x_ready at posedge clk.
- State: locked (1b), owner (2b: RING=0, LOCAL=1, EXT=2), rr_ptr (2b).
- Selection while unlocked (combinational, same cycle):
  - Candidates are inputs with valid=1.
  - RING_PRIO=1: pick ring if valid, else the first valid of local, ext in rr order starting at rr_ptr.
  - RING_PRIO=0: pick the first valid input in cyclic order RING→LOCAL→EXT, starting at rr_ptr.
- Selection while locked: sel = owner, regardless of other inputs' valid.
- Datapath: out_ring = in_sel (data, last, valid). If no input is selected, out_ring.valid=0 and data/last are don't-care (drive 0).
- Ready: in_sel_ready = out_ring_ready; the non-selected inputs' ready = 0. out_ring.valid never depends on out_ring_ready.
- Lock transitions:
  - Unlocked, transfer of a flit with last=0 → locked=1, owner=sel.
  - Locked, transfer of a flit with last=1 → locked=0, rr_ptr=(owner+1) mod 3.
  - Single-flit worm (last=1 on the first flit): no lock; rr_ptr=(sel+1) mod 3.
- Locked owner deasserts valid mid-worm (bubble): out_ring.valid=0 and the lock is held; other inputs stay blocked.
- out_ring_ready=0: the selection is held (no change to locked/rr_ptr); the selected input sees ready=0.
- Latency: 0 cycles (combinational path) without the optional feature. Throughput is 1 flit/cycle.
- Reset mid-worm: lock dropped immediately. The remainder of the worm is arbitrated as a new worm after reset release; the upstream side is also reset by the system.

Optional Feature:
RING_ROUTER_GATEWAY_MUX_OUTREG_EN
- Defined: out_ring is driven from a 2-entry skid buffer.
  - out_ring.valid/data/last come from flops; out_ring_ready feeds only the buffer.
  - in_sel_ready = buffer not full.
  - Latency 1 cycle; sustains 1 flit/cycle with out_ring_ready=1.
  - Buffer empty after reset. Lock/rr logic advances on input transfers, not output transfers.
- Undefined: purely combinational datapath as described above.

Test Plan:
1. Single source: in_local sends a 3-flit worm 0x0005, 0x1234, 0xABCD(last), out_ring_ready=1 → out_ring carries the same 3 flits in consecutive cycles; in_ring_ready=in_ext_ready=0 throughout; rr_ptr=EXT after.
2. Contention, RING_PRIO=0: all three present 2-flit worms in the same cycle after reset → order ring, local, ext; no interleaving; 6 transfers in 6 cycles.
3. Contention, RING_PRIO=1: ring and ext both continuously valid with 1-flit worms → ring wins every cycle; ext stalls (in_ext_ready=0).
4. Backpressure: mid-worm out_ring_ready=0 for 3 cycles → the out_ring flit is held stable; owner ready=0; the lock persists; resumes on the same owner.
5. Bubble: owner ext drops valid for 2 cycles mid-worm while in_ring is valid → out_ring.valid=0 in those cycles; in_ring_ready=0; the ext worm then completes.
6. Reset: assert rst_n=0 asynchronously mid-worm → out_ring.valid=0 and all readies 0 immediately. After release, a new in_ring flit passes in the same cycle.
7. OUTREG_EN build: repeat scenario 2 → identical flit order with +1 cycle latency and no lost or duplicated flits.
